// File: rtl/hero_bus_if.sv
// hero_bus_if: bundles the requester-side and sink-side signals of the
// hero bus arbiter.
//   req_cycle_type/req_wdat/req_clk_en : per-requester beats, slice i = requester i
//   req_ready                          : per-requester accept strobe
//   out_cycle_type/out_wdat/out_clk_en : registered hero_write stage toward the sink
//   out_ready                          : sink backpressure
//   out_owner                          : requester index of the beat on out_*
//   busy, timeout_err                  : status
// Modport slave is the arbiter's view; modport master is the environment's view.
interface hero_bus_if #(
  parameter int NUM_REQ    = 4,
  parameter int HERO_WIDTH = 36,
  parameter int CT_WIDTH   = 4
);
  localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ*CT_WIDTH-1:0]   req_cycle_type;
  logic [NUM_REQ*HERO_WIDTH-1:0] req_wdat;
  logic [NUM_REQ-1:0]            req_clk_en;
  logic [NUM_REQ-1:0]            req_ready;
  logic [CT_WIDTH-1:0]           out_cycle_type;
  logic [HERO_WIDTH-1:0]         out_wdat;
  logic                          out_clk_en;
  logic                          out_ready;
  logic [OWN_W-1:0]              out_owner;
  logic                          busy;
  logic                          timeout_err;

  modport slave (
    input  req_cycle_type, req_wdat, req_clk_en, out_ready,
    output req_ready, out_cycle_type, out_wdat, out_clk_en, out_owner,
           busy, timeout_err
  );

  modport master (
    output req_cycle_type, req_wdat, req_clk_en, out_ready,
    input  req_ready, out_cycle_type, out_wdat, out_clk_en, out_owner,
           busy, timeout_err
  );
endinterface

// File: rtl/hero_bus_arbiter.sv
// hero_bus_arbiter: shares one hero write bus among NUM_REQ requesters,
// granting whole transactions (VALID* DONE) in round-robin order.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : hero_bus_if.slave (requester beats in, req_ready out, registered
//          out_* stage toward the sink, out_ready in, busy/timeout_err status)
// Optional feature macro: HERO_ARB_TIMEOUT_EN -- when defined, an owner that
// stays IDLE for MAX_STALL cycles is terminated with an arbiter-generated DONE
// and timeout_err pulses; when undefined the lock is held indefinitely.
module hero_bus_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int HERO_WIDTH = 36,
  parameter int CT_WIDTH   = 4,
  parameter int MAX_STALL  = 16
) (
  input logic       clk,
  input logic       rst,
  hero_bus_if.slave bus
);
  localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CT_WIDTH-1:0] CT_IDLE  = CT_WIDTH'(0);
  localparam logic [CT_WIDTH-1:0] CT_VALID = CT_WIDTH'(1);
  localparam logic [CT_WIDTH-1:0] CT_DONE  = CT_WIDTH'(2);

  typedef enum logic [0:0] {
    ST_ARB = 1'b0,
    ST_OWN = 1'b1
  } state_t;

  state_t                state_r, state_s;
  logic [OWN_W-1:0]      rr_ptr_r, rr_ptr_s;
  logic [OWN_W-1:0]      owner_r, owner_s;
  logic [NUM_REQ-1:0]    cand_s;
  logic [NUM_REQ-1:0]    ready_s;
  logic [OWN_W-1:0]      win_s;
  logic                  found_s;
  logic [OWN_W-1:0]      sel_s;
  logic                  sel_hit_s;
  logic [CT_WIDTH-1:0]   sel_ct_s;
  logic [HERO_WIDTH-1:0] sel_wdat_s;
  logic                  sel_ce_s;
  logic                  sel_is_valid_s;
  logic                  sel_is_done_s;
  logic                  out_free_s;
  logic                  accept_s;
  logic                  force_s;

  logic [CT_WIDTH-1:0]   out_ct_r;
  logic [HERO_WIDTH-1:0] out_wdat_r;
  logic                  out_ce_r;
  logic [OWN_W-1:0]      out_owner_r;
  logic                  timeout_err_r;

  // Index base+k reduced modulo NUM_REQ (k < NUM_REQ, so one subtraction suffices).
  function automatic logic [OWN_W-1:0] rr_idx(input logic [OWN_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) begin
      s = s - NUM_REQ;
    end else begin
      s = s;
    end
    return OWN_W'(s);
  endfunction

  // Successor of a requester index, wrapping at NUM_REQ.
  function automatic logic [OWN_W-1:0] inc_wrap(input logic [OWN_W-1:0] v);
    if (int'(v) == NUM_REQ - 1) begin
      return OWN_W'(0);
    end else begin
      return v + OWN_W'(1);
    end
  endfunction

  // The output slot can take a new beat when it is empty or being drained.
  assign out_free_s = (out_ct_r == CT_IDLE) || bus.out_ready;

  // Candidate decode: only VALID and DONE count; illegal codes behave as IDLE.
  always_comb begin
    cand_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s[i] = (bus.req_cycle_type[i*CT_WIDTH +: CT_WIDTH] == CT_VALID) ||
                  (bus.req_cycle_type[i*CT_WIDTH +: CT_WIDTH] == CT_DONE);
    end
  end

  // Round-robin search: first candidate at or after rr_ptr, with wrap.
  always_comb begin
    found_s = 1'b0;
    win_s   = OWN_W'(0);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found_s && cand_s[rr_idx(rr_ptr_r, k)]) begin
        found_s = 1'b1;
        win_s   = rr_idx(rr_ptr_r, k);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Selected requester: the owner while locked, otherwise the arbitration winner.
  always_comb begin
    if (state_r == ST_OWN) begin
      sel_s     = owner_r;
      sel_hit_s = 1'b1;
    end else begin
      sel_s     = win_s;
      sel_hit_s = found_s;
    end
  end

  // Mux the selected requester's beat.
  always_comb begin
    sel_ct_s   = CT_IDLE;
    sel_wdat_s = '0;
    sel_ce_s   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (OWN_W'(i) == sel_s) begin
        sel_ct_s   = bus.req_cycle_type[i*CT_WIDTH +: CT_WIDTH];
        sel_wdat_s = bus.req_wdat[i*HERO_WIDTH +: HERO_WIDTH];
        sel_ce_s   = bus.req_clk_en[i];
      end else begin
        sel_ct_s = sel_ct_s;
      end
    end
  end

  assign sel_is_valid_s = (sel_ct_s == CT_VALID);
  assign sel_is_done_s  = (sel_ct_s == CT_DONE);

  // Ready goes only to the selected requester; an IDLE owner still sees ready
  // but nothing is accepted from it. Ready is withheld in a forced-DONE cycle.
  always_comb begin
    ready_s = '0;
    if (sel_hit_s && out_free_s && !force_s) begin
      ready_s[sel_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  assign accept_s = ready_s[sel_s] && (sel_is_valid_s || sel_is_done_s);

`ifdef HERO_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(MAX_STALL + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(MAX_STALL);
  logic [STALL_W-1:0] stall_r;

  assign force_s = (state_r == ST_OWN) && (stall_r == STALL_MAX) && out_free_s;

  // Consecutive owner-IDLE cycles in OWN; cleared by any accepted beat or leaving OWN.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_r <= STALL_W'(0);
    end else if ((state_r != ST_OWN) || accept_s || force_s) begin
      stall_r <= STALL_W'(0);
    end else if (!cand_s[owner_r] && (stall_r != STALL_MAX)) begin
      stall_r <= stall_r + STALL_W'(1);
    end else begin
      stall_r <= stall_r;
    end
  end
`else
  // No stall termination: the comparison is false for every legal MAX_STALL.
  assign force_s = (MAX_STALL < 0);
`endif

  // Grant FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_ARB;
    end else begin
      state_r <= state_s;
    end
  end

  // Grant FSM next state, round-robin pointer and owner updates.
  always_comb begin
    state_s  = state_r;
    rr_ptr_s = rr_ptr_r;
    owner_s  = owner_r;
    case (state_r)
      ST_ARB: begin
        if (accept_s && sel_is_valid_s) begin
          state_s = ST_OWN;
          owner_s = sel_s;
        end else if (accept_s && sel_is_done_s) begin
          rr_ptr_s = inc_wrap(sel_s);
        end else begin
          state_s = ST_ARB;
        end
      end
      ST_OWN: begin
        if (force_s || (accept_s && sel_is_done_s)) begin
          state_s  = ST_ARB;
          rr_ptr_s = inc_wrap(owner_r);
        end else begin
          state_s = ST_OWN;
        end
      end
      default: begin
        state_s = ST_ARB;
      end
    endcase
  end

  // Pointer and owner registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r <= OWN_W'(0);
      owner_r  <= OWN_W'(0);
    end else begin
      rr_ptr_r <= rr_ptr_s;
      owner_r  <= owner_s;
    end
  end

  // Registered hero_write stage: load accepted beat, forced DONE, or bubble;
  // hold everything while a beat is stalled by the sink.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_ct_r    <= CT_IDLE;
      out_wdat_r  <= '0;
      out_ce_r    <= 1'b0;
      out_owner_r <= OWN_W'(0);
    end else if (out_free_s) begin
      if (accept_s) begin
        out_ct_r    <= sel_is_done_s ? CT_DONE : CT_VALID;
        out_wdat_r  <= sel_wdat_s;
        out_ce_r    <= sel_ce_s;
        out_owner_r <= sel_s;
      end else if (force_s) begin
        out_ct_r    <= CT_DONE;
        out_wdat_r  <= '0;
        out_ce_r    <= 1'b0;
        out_owner_r <= owner_r;
      end else begin
        out_ct_r    <= CT_IDLE;
        out_ce_r    <= 1'b0;
      end
    end else begin
      out_ct_r    <= out_ct_r;
      out_wdat_r  <= out_wdat_r;
      out_ce_r    <= out_ce_r;
      out_owner_r <= out_owner_r;
    end
  end

  // Timeout pulse aligned with the forced DONE on out_*.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_err_r <= 1'b0;
    end else begin
      timeout_err_r <= force_s;
    end
  end

  assign bus.req_ready      = ready_s;
  assign bus.out_cycle_type = out_ct_r;
  assign bus.out_wdat       = out_wdat_r;
  assign bus.out_clk_en     = out_ce_r;
  assign bus.out_owner      = out_owner_r;
  assign bus.busy           = (state_r == ST_OWN);
  assign bus.timeout_err    = timeout_err_r;
endmodule

// File: tb/tb_hero_bus_arbiter.sv
// Self-checking bench for hero_bus_arbiter: directed scenarios plus random
// traffic, all compared against a transaction-level reference model.
module tb_hero_bus_arbiter;
  localparam int N  = 4;
  localparam int HW = 36;
  localparam int CW = 4;
  localparam int MS = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hero_bus_if #(.NUM_REQ(N), .HERO_WIDTH(HW), .CT_WIDTH(CW)) hb ();

  hero_bus_arbiter #(.NUM_REQ(N), .HERO_WIDTH(HW), .CT_WIDTH(CW), .MAX_STALL(MS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (hb)
  );

  int err_cnt = 0;
  int chk_cnt = 0;

  // reference model state
  bit          m_own;
  int          m_owner, m_rr, m_out_ct, m_out_owner, m_stall;
  logic [HW-1:0] m_out_wdat;
  bit          m_out_ce, m_terr;

  // per-cycle stimulus
  int          ct[N];
  logic [HW-1:0] wd[N];
  bit          ce[N];
  bit          ordy;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit legal(input int c);
    return (c == 1) || (c == 2);
  endfunction

  task automatic model_reset();
    m_own = 0; m_owner = 0; m_rr = 0; m_out_ct = 0; m_out_owner = 0;
    m_stall = 0; m_out_wdat = '0; m_out_ce = 0; m_terr = 0;
  endtask

  task automatic set_idle();
    for (int i = 0; i < N; i++) begin
      ct[i] = 0; wd[i] = '0; ce[i] = 0;
    end
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model after the rising edge.
  task automatic step(input bit do_rst);
    bit free, frc, acc;
    int sel;
    logic [N-1:0] exp_rdy;
    rst = do_rst;
    hb.out_ready = ordy;
    for (int i = 0; i < N; i++) begin
      hb.req_cycle_type[i*CW +: CW] = CW'(ct[i]);
      hb.req_wdat[i*HW +: HW]       = wd[i];
      hb.req_clk_en[i]              = ce[i];
    end
    #4;
    free = (m_out_ct == 0) || ordy;
    frc = 0;
`ifdef HERO_ARB_TIMEOUT_EN
    frc = m_own && (m_stall >= MS) && free;
`endif
    sel = -1;
    if (m_own) sel = m_owner;
    else begin
      for (int k = 0; k < N; k++) begin
        if (sel < 0 && legal(ct[(m_rr + k) % N])) sel = (m_rr + k) % N;
      end
    end
    exp_rdy = '0;
    if (sel >= 0 && free && !frc) exp_rdy[sel] = 1'b1;
    acc = (sel >= 0) && exp_rdy[sel] && legal(ct[sel]);

    check_val("req_ready",   64'(hb.req_ready),      64'(exp_rdy));
    check_val("out_ct",      64'(hb.out_cycle_type), 64'(m_out_ct));
    check_val("out_wdat",    64'(hb.out_wdat),       64'(m_out_wdat));
    check_val("out_clk_en",  64'(hb.out_clk_en),     64'(m_out_ce));
    check_val("out_owner",   64'(hb.out_owner),      64'(m_out_owner));
    check_val("busy",        64'(hb.busy),           64'(m_own));
    check_val("timeout_err", 64'(hb.timeout_err),    64'(m_terr));

    @(posedge clk);
    #1;
    if (do_rst) begin
      model_reset();
    end else begin
      if (free) begin
        if (acc) begin
          m_out_ct = ct[sel]; m_out_wdat = wd[sel]; m_out_ce = ce[sel]; m_out_owner = sel;
        end else if (frc) begin
          m_out_ct = 2; m_out_wdat = '0; m_out_ce = 0; m_out_owner = m_owner;
        end else begin
          m_out_ct = 0; m_out_ce = 0;
        end
      end
      m_terr = frc;
      if (!m_own || acc || frc) m_stall = 0;
      else if (!legal(ct[m_owner]) && m_stall < MS) m_stall++;
      if (frc) begin
        m_own = 0; m_rr = (m_owner + 1) % N;
      end else if (acc) begin
        if (ct[sel] == 1 && !m_own) begin
          m_own = 1; m_owner = sel;
        end else if (ct[sel] == 2) begin
          m_own = 0; m_rr = (sel + 1) % N;
        end
      end
    end
  endtask

  initial begin
    logic [63:0] rnd;
    int r;
    set_idle();
    ordy = 1;
    rst = 1;
    hb.out_ready = 1'b1;
    hb.req_cycle_type = '0;
    hb.req_wdat = '0;
    hb.req_clk_en = '0;
    @(posedge clk);
    #1;
    model_reset();
    step(1);
    step(0);
    check_val("rst_out_ct", 64'(hb.out_cycle_type), 64'd0);
    check_val("rst_busy",   64'(hb.busy),           64'd0);

    // single-beat DONE from req0
    ct[0] = 2; wd[0] = 36'h5; ce[0] = 1;
    step(0);
    check_val("t1_ct",    64'(hb.out_cycle_type), 64'd2);
    check_val("t1_wdat",  64'(hb.out_wdat),       64'h5);
    check_val("t1_owner", 64'(hb.out_owner),      64'd0);
    check_val("t1_busy",  64'(hb.busy),           64'd0);
    set_idle();

    // req1 VALID,VALID,DONE while req2 keeps presenting VALID
    ct[2] = 1; wd[2] = 36'h22;
    ct[1] = 1; wd[1] = 36'hA; step(0);
    check_val("t2_a", 64'(hb.out_wdat), 64'hA);
    wd[1] = 36'hB; step(0);
    check_val("t2_b", 64'(hb.out_wdat), 64'hB);
    ct[1] = 2; wd[1] = 36'hC; step(0);
    check_val("t2_c",     64'(hb.out_wdat),  64'hC);
    check_val("t2_owner", 64'(hb.out_owner), 64'd1);
    ct[1] = 0; step(0);
    check_val("t2_req2", 64'(hb.out_owner), 64'd2);
    ct[2] = 2; step(0);
    set_idle(); step(0);

    // all DONE from rr_ptr=0: 0,1,2,3,0
    step(1);
    for (int i = 0; i < N; i++) begin ct[i] = 2; wd[i] = HW'(i + 16); end
    for (int i = 0; i < 5; i++) begin
      step(0);
      check_val("t3_order", 64'(hb.out_owner), 64'(i % N));
    end
    set_idle(); step(0);

    // backpressure on a VALID beat
    ct[0] = 1; wd[0] = 36'h77; step(0);
    ordy = 0;
    for (int i = 0; i < 3; i++) begin
      step(0);
      check_val("t4_hold", 64'(hb.out_wdat), 64'h77);
    end
    ordy = 1; ct[0] = 2; wd[0] = 36'h78; step(0);
    check_val("t4_next", 64'(hb.out_wdat), 64'h78);
    set_idle(); step(0);

    // owner 1 idles for 5 cycles mid-transaction while others request
    step(1);
    ct[1] = 1; wd[1] = 36'h100; step(0);
    ct[1] = 0; ct[0] = 1; ct[2] = 2; ct[3] = 1;
    for (int i = 0; i < 5; i++) begin
      step(0);
      check_val("t5_busy", 64'(hb.busy),           64'd1);
      check_val("t5_idle", 64'(hb.out_cycle_type), 64'd0);
    end
    ct[1] = 2; wd[1] = 36'h101; step(0);
    check_val("t5_done", 64'(hb.out_cycle_type), 64'd2);
    set_idle(); step(0);

    // reset mid-transaction abandons the lock
    ct[3] = 1; step(0);
    step(1);
    check_val("t6_ct",   64'(hb.out_cycle_type), 64'd0);
    check_val("t6_busy", 64'(hb.busy),           64'd0);
    set_idle(); step(0);

`ifdef HERO_ARB_TIMEOUT_EN
    // owner 2 stalls until forced termination
    step(1);
    ct[2] = 1; wd[2] = 36'h9; step(0);
    ct[2] = 0;
    for (int i = 0; i < MS; i++) step(0);
    step(0);
    check_val("t7_ct",   64'(hb.out_cycle_type), 64'd2);
    check_val("t7_wdat", 64'(hb.out_wdat),       64'd0);
    check_val("t7_terr", 64'(hb.timeout_err),    64'd1);
    check_val("t7_busy", 64'(hb.busy),           64'd0);
    ct[3] = 2; ct[0] = 2; step(0);
    check_val("t7_next", 64'(hb.out_owner), 64'd3);
    set_idle(); step(0);
`endif

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        r = $urandom_range(0, 19);
        if (r < 5) ct[i] = 0;
        else if (r < 12) ct[i] = 1;
        else if (r < 18) ct[i] = 2;
        else ct[i] = 3 + $urandom_range(0, 12);
        rnd = {$urandom, $urandom};
        wd[i] = rnd[HW-1:0];
        ce[i] = $urandom_range(0, 1) == 1;
      end
      ordy = $urandom_range(0, 3) != 0;
      step($urandom_range(0, 299) == 0);
    end

    set_idle(); ordy = 1;
    step(0);
    step(0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
